// File: rtl/axi4_aflag_width_pipe.sv
// ============================================================================
// Module  : axi4_aflag_width_pipe
// Brief   : AXI4 AW/AR descriptor width adapter with one register stage.
//           Recomputes len/size for an OSIZE-bit bus, passes other fields.
//           Optional macro AFLAG_ADDR_ALIGN_EN: widen-case address alignment.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module axi4_aflag_width_pipe #(
   parameter string MODE   = "WRITE",
   parameter int    IDSIZE = 4,
   parameter int    ASIZE  = 32,
   parameter int    ILSIZE = 8,
   parameter int    OLSIZE = 8,
   parameter int    ISIZE  = 32,
   parameter int    OSIZE  = 256
) (
   input  logic              clock,
   input  logic              rst,
   input  logic [IDSIZE-1:0] in_a_id,
   input  logic [ASIZE-1:0]  in_a_addr,
   input  logic [ILSIZE-1:0] in_a_len,
   input  logic [2:0]        in_a_size,
   input  logic [1:0]        in_a_burst,
   input  logic              in_a_lock,
   input  logic [3:0]        in_a_cache,
   input  logic [2:0]        in_a_prot,
   input  logic [3:0]        in_a_qos,
   input  logic              in_a_valid,
   output logic              in_a_ready,
   output logic [IDSIZE-1:0] out_a_id,
   output logic [ASIZE-1:0]  out_a_addr,
   output logic [OLSIZE-1:0] out_a_len,
   output logic [2:0]        out_a_size,
   output logic [1:0]        out_a_burst,
   output logic              out_a_lock,
   output logic [3:0]        out_a_cache,
   output logic [2:0]        out_a_prot,
   output logic [3:0]        out_a_qos,
   output logic              out_a_valid,
   input  logic              out_a_ready
);

   localparam int         IBL      = $clog2(ISIZE / 8);
   localparam int         OBL      = $clog2(OSIZE / 8);
   localparam bit         WIDEN    = (OSIZE > ISIZE);
   localparam bit         NARROW   = (OSIZE < ISIZE);
   localparam int         RLOG     = WIDEN ? (OBL - IBL) : (NARROW ? (IBL - OBL) : 0);
   localparam int         CW       = ILSIZE + RLOG + 1;
   localparam logic [2:0] OUT_SIZE = 3'(OBL);

   logic [CW-1:0]     w_beats_m1;
   logic [ASIZE-1:0]  w_addr;
   logic [OLSIZE-1:0] w_len;
   logic              unused_ok;

   // The requested size is implied by the bus width, so in_a_size is not needed.
   assign unused_ok = ^in_a_size;

   generate
      if (MODE != "WRITE" && MODE != "READ") begin : g_bad_mode
         $error("axi4_aflag_width_pipe: MODE must be \"WRITE\" or \"READ\"");
      end

      if (WIDEN) begin : g_widen
`ifdef AFLAG_ADDR_ALIGN_EN
         localparam logic [ASIZE-1:0] ALIGN_MASK = ~((ASIZE'(1) << OBL) - ASIZE'(1));
         logic [CW-1:0] w_sum;
         // ceil((off+len+1)/R)-1 reduces to floor((off+len)/R).
         assign w_sum      = CW'(in_a_len) + CW'(in_a_addr[OBL-1:IBL]);
         assign w_beats_m1 = w_sum >> RLOG;
         assign w_addr     = in_a_addr & ALIGN_MASK;
`else
         // ceil((len+1)/R)-1 reduces to floor(len/R).
         assign w_beats_m1 = CW'(in_a_len) >> RLOG;
         assign w_addr     = in_a_addr;
`endif
      end else if (NARROW) begin : g_narrow
         // (len+1)*R-1 is len shifted left with the vacated bits set.
         assign w_beats_m1 = {1'b0, in_a_len, {RLOG{1'b1}}};
         assign w_addr     = in_a_addr;
      end else begin : g_equal
         assign w_beats_m1 = CW'(in_a_len);
         assign w_addr     = in_a_addr;
      end

      if (OLSIZE >= CW) begin : g_no_sat
         assign w_len = OLSIZE'(w_beats_m1);
      end else begin : g_sat
         assign w_len = (|w_beats_m1[CW-1:OLSIZE]) ? {OLSIZE{1'b1}} : w_beats_m1[OLSIZE-1:0];
      end
   endgenerate

   assign in_a_ready = !out_a_valid || out_a_ready;

   always_ff @(posedge clock) begin
      if (rst) begin
         out_a_valid <= 1'b0;
         out_a_id    <= '0;
         out_a_addr  <= '0;
         out_a_len   <= '0;
         out_a_size  <= '0;
         out_a_burst <= '0;
         out_a_lock  <= 1'b0;
         out_a_cache <= '0;
         out_a_prot  <= '0;
         out_a_qos   <= '0;
      end else if (in_a_valid && in_a_ready) begin
         out_a_valid <= 1'b1;
         out_a_id    <= in_a_id;
         out_a_addr  <= w_addr;
         out_a_len   <= w_len;
         out_a_size  <= OUT_SIZE;
         out_a_burst <= in_a_burst;
         out_a_lock  <= in_a_lock;
         out_a_cache <= in_a_cache;
         out_a_prot  <= in_a_prot;
         out_a_qos   <= in_a_qos;
      end else if (out_a_ready) begin
         out_a_valid <= 1'b0;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_axi4_aflag_width_pipe.sv
// Directed bench for axi4_aflag_width_pipe: a widening (32->256) and a
// narrowing (256->32) instance share clock and reset.
`default_nettype none

module tb_axi4_aflag_width_pipe;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int n_cmp  = 0;
   int n_fail = 0;

   // widening instance
   logic [3:0]  w_id = '0;
   logic [31:0] w_addr = '0;
   logic [7:0]  w_len = '0;
   logic [2:0]  w_size = 3'd2;
   logic [1:0]  w_burst = 2'd1;
   logic        w_lock = 1'b0;
   logic [3:0]  w_cache = '0;
   logic [2:0]  w_prot = '0;
   logic [3:0]  w_qos = '0;
   logic        w_valid = 1'b0;
   logic        w_in_ready;
   logic [3:0]  wo_id;
   logic [31:0] wo_addr;
   logic [7:0]  wo_len;
   logic [2:0]  wo_size;
   logic [1:0]  wo_burst;
   logic        wo_lock;
   logic [3:0]  wo_cache;
   logic [2:0]  wo_prot;
   logic [3:0]  wo_qos;
   logic        wo_valid;
   logic        wo_ready = 1'b1;

   // narrowing instance
   logic [3:0]  n_id = 4'h9;
   logic [31:0] n_addr = 32'h40;
   logic [7:0]  n_len = '0;
   logic [2:0]  n_size = 3'd5;
   logic [1:0]  n_burst = 2'd1;
   logic        n_lock = 1'b0;
   logic [3:0]  n_cache = '0;
   logic [2:0]  n_prot = '0;
   logic [3:0]  n_qos = '0;
   logic        n_valid = 1'b0;
   logic        n_in_ready;
   logic [3:0]  no_id;
   logic [31:0] no_addr;
   logic [7:0]  no_len;
   logic [2:0]  no_size;
   logic [1:0]  no_burst;
   logic        no_lock;
   logic [3:0]  no_cache;
   logic [2:0]  no_prot;
   logic [3:0]  no_qos;
   logic        no_valid;
   logic        no_ready = 1'b1;

   axi4_aflag_width_pipe #(
      .MODE("WRITE"), .IDSIZE(4), .ASIZE(32), .ILSIZE(8), .OLSIZE(8),
      .ISIZE(32), .OSIZE(256)
   ) u_wide (
      .clock(clk), .rst(rst),
      .in_a_id(w_id), .in_a_addr(w_addr), .in_a_len(w_len), .in_a_size(w_size),
      .in_a_burst(w_burst), .in_a_lock(w_lock), .in_a_cache(w_cache),
      .in_a_prot(w_prot), .in_a_qos(w_qos), .in_a_valid(w_valid),
      .in_a_ready(w_in_ready),
      .out_a_id(wo_id), .out_a_addr(wo_addr), .out_a_len(wo_len),
      .out_a_size(wo_size), .out_a_burst(wo_burst), .out_a_lock(wo_lock),
      .out_a_cache(wo_cache), .out_a_prot(wo_prot), .out_a_qos(wo_qos),
      .out_a_valid(wo_valid), .out_a_ready(wo_ready)
   );

   axi4_aflag_width_pipe #(
      .MODE("READ"), .IDSIZE(4), .ASIZE(32), .ILSIZE(8), .OLSIZE(8),
      .ISIZE(256), .OSIZE(32)
   ) u_narrow (
      .clock(clk), .rst(rst),
      .in_a_id(n_id), .in_a_addr(n_addr), .in_a_len(n_len), .in_a_size(n_size),
      .in_a_burst(n_burst), .in_a_lock(n_lock), .in_a_cache(n_cache),
      .in_a_prot(n_prot), .in_a_qos(n_qos), .in_a_valid(n_valid),
      .in_a_ready(n_in_ready),
      .out_a_id(no_id), .out_a_addr(no_addr), .out_a_len(no_len),
      .out_a_size(no_size), .out_a_burst(no_burst), .out_a_lock(no_lock),
      .out_a_cache(no_cache), .out_a_prot(no_prot), .out_a_qos(no_qos),
      .out_a_valid(no_valid), .out_a_ready(no_ready)
   );

   // inputs change and outputs are sampled 1 time unit after the rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      n_cmp++; if (wo_valid !== 1'b0) begin $display("FAIL reset_valid got %0b exp 0", wo_valid); n_fail++; end
      n_cmp++; if (wo_len !== 8'd0) begin $display("FAIL reset_len got %0d exp 0", wo_len); n_fail++; end
      n_cmp++; if (w_in_ready !== 1'b1) begin $display("FAIL reset_in_ready got %0b exp 1", w_in_ready); n_fail++; end
      n_cmp++; if (no_valid !== 1'b0) begin $display("FAIL reset_narrow_valid got %0b exp 0", no_valid); n_fail++; end
   endtask

   task automatic test_widen();
      wo_ready = 1'b1;
      w_valid = 1'b1; w_len = 8'd15; w_id = 4'h3; w_addr = 32'h0000_1000; w_qos = 4'h5;
      tick();
      n_cmp++; if (wo_valid !== 1'b1) begin $display("FAIL widen_valid0 got %0b exp 1", wo_valid); n_fail++; end
      n_cmp++; if (wo_len !== 8'd1) begin $display("FAIL widen_len15 got %0d exp 1", wo_len); n_fail++; end
      n_cmp++; if (wo_size !== 3'd5) begin $display("FAIL widen_size got %0d exp 5", wo_size); n_fail++; end
      n_cmp++; if (wo_id !== 4'h3) begin $display("FAIL widen_id got %0h exp 3", wo_id); n_fail++; end
      n_cmp++; if (wo_addr !== 32'h0000_1000) begin $display("FAIL widen_addr got %0h exp 1000", wo_addr); n_fail++; end
      n_cmp++; if (wo_qos !== 4'h5) begin $display("FAIL widen_qos got %0h exp 5", wo_qos); n_fail++; end
      w_len = 8'd0; w_id = 4'h4; w_addr = 32'h0000_2000; w_qos = 4'hA;
      tick();
      n_cmp++; if (wo_len !== 8'd0) begin $display("FAIL widen_len0 got %0d exp 0", wo_len); n_fail++; end
      n_cmp++; if (wo_id !== 4'h4) begin $display("FAIL widen_id1 got %0h exp 4", wo_id); n_fail++; end
      n_cmp++; if (wo_addr !== 32'h0000_2000) begin $display("FAIL widen_addr1 got %0h exp 2000", wo_addr); n_fail++; end
      w_len = 8'd8; w_id = 4'h5; w_qos = 4'h1;
      tick();
      n_cmp++; if (wo_len !== 8'd1) begin $display("FAIL widen_len8 got %0d exp 1", wo_len); n_fail++; end
      n_cmp++; if (wo_qos !== 4'h1) begin $display("FAIL widen_qos2 got %0h exp 1", wo_qos); n_fail++; end
      w_valid = 1'b0;
      tick();
      n_cmp++; if (wo_valid !== 1'b0) begin $display("FAIL widen_drain got %0b exp 0", wo_valid); n_fail++; end
   endtask

   task automatic test_narrow();
      no_ready = 1'b1;
      n_valid = 1'b1; n_len = 8'd1;
      tick();
      n_cmp++; if (no_len !== 8'd15) begin $display("FAIL narrow_len got %0d exp 15", no_len); n_fail++; end
      n_cmp++; if (no_size !== 3'd2) begin $display("FAIL narrow_size got %0d exp 2", no_size); n_fail++; end
      n_cmp++; if (no_addr !== 32'h40) begin $display("FAIL narrow_addr got %0h exp 40", no_addr); n_fail++; end
      n_len = 8'd255;
      tick();
      n_cmp++; if (no_len !== 8'd255) begin $display("FAIL narrow_saturate got %0d exp 255", no_len); n_fail++; end
      n_len = 8'd31;
      tick();
      n_cmp++; if (no_len !== 8'd255) begin $display("FAIL narrow_len31 got %0d exp 255", no_len); n_fail++; end
      n_len = 8'd30;
      tick();
      n_cmp++; if (no_len !== 8'd247) begin $display("FAIL narrow_len30 got %0d exp 247", no_len); n_fail++; end
      n_valid = 1'b0;
      tick();
      n_cmp++; if (no_valid !== 1'b0) begin $display("FAIL narrow_drain got %0b exp 0", no_valid); n_fail++; end
   endtask

   task automatic test_back_to_back();
      wo_ready = 1'b0;
      w_valid = 1'b1; w_len = 8'd15; w_id = 4'h1; w_addr = 32'h0000_3000;
      tick();
      n_cmp++; if (wo_valid !== 1'b1) begin $display("FAIL bp_valid got %0b exp 1", wo_valid); n_fail++; end
      n_cmp++; if (w_in_ready !== 1'b0) begin $display("FAIL bp_in_ready got %0b exp 0", w_in_ready); n_fail++; end
      w_len = 8'd0; w_id = 4'h2; w_addr = 32'h0000_4000;
      tick();
      tick();
      n_cmp++; if (wo_id !== 4'h1) begin $display("FAIL bp_hold_id got %0h exp 1", wo_id); n_fail++; end
      n_cmp++; if (wo_len !== 8'd1) begin $display("FAIL bp_hold_len got %0d exp 1", wo_len); n_fail++; end
      n_cmp++; if (wo_addr !== 32'h0000_3000) begin $display("FAIL bp_hold_addr got %0h exp 3000", wo_addr); n_fail++; end
      wo_ready = 1'b1;
      #1;
      n_cmp++; if (w_in_ready !== 1'b1) begin $display("FAIL bp_release_ready got %0b exp 1", w_in_ready); n_fail++; end
      tick();
      n_cmp++; if (wo_valid !== 1'b1) begin $display("FAIL bp_no_bubble got %0b exp 1", wo_valid); n_fail++; end
      n_cmp++; if (wo_id !== 4'h2) begin $display("FAIL bp_second_id got %0h exp 2", wo_id); n_fail++; end
      n_cmp++; if (wo_len !== 8'd0) begin $display("FAIL bp_second_len got %0d exp 0", wo_len); n_fail++; end
      w_valid = 1'b0;
      tick();
      n_cmp++; if (wo_valid !== 1'b0) begin $display("FAIL bp_drain got %0b exp 0", wo_valid); n_fail++; end
   endtask

   task automatic test_align();
      logic [31:0] exp_addr;
      logic [7:0]  exp_len;
`ifdef AFLAG_ADDR_ALIGN_EN
      exp_addr = 32'h0000_0000; exp_len = 8'd1;
`else
      exp_addr = 32'h0000_001C; exp_len = 8'd0;
`endif
      wo_ready = 1'b1;
      w_valid = 1'b1; w_len = 8'd1; w_id = 4'h6; w_addr = 32'h0000_001C;
      tick();
      w_valid = 1'b0;
      n_cmp++; if (wo_addr !== exp_addr) begin $display("FAIL align_addr got %0h exp %0h", wo_addr, exp_addr); n_fail++; end
      n_cmp++; if (wo_len !== exp_len) begin $display("FAIL align_len got %0d exp %0d", wo_len, exp_len); n_fail++; end
      tick();
   endtask

   task automatic test_reset_midflight();
      wo_ready = 1'b0;
      w_valid = 1'b1; w_len = 8'd16; w_id = 4'h7; w_addr = 32'h0000_5000;
      tick();
      w_valid = 1'b0;
      n_cmp++; if (wo_len !== 8'd2) begin $display("FAIL mid_len got %0d exp 2", wo_len); n_fail++; end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      n_cmp++; if (wo_valid !== 1'b0) begin $display("FAIL mid_reset_valid got %0b exp 0", wo_valid); n_fail++; end
      n_cmp++; if (wo_id !== 4'h0) begin $display("FAIL mid_reset_id got %0h exp 0", wo_id); n_fail++; end
      n_cmp++; if (w_in_ready !== 1'b1) begin $display("FAIL mid_reset_ready got %0b exp 1", w_in_ready); n_fail++; end
      wo_ready = 1'b1;
   endtask

   initial begin
      test_reset();
      test_widen();
      test_narrow();
      test_back_to_back();
      test_align();
      test_reset_midflight();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
